// File: rtl/backprop_sequencer.sv
// Backprop control sequencer: one cost word, then every row of each dense layer
// from last to first, with drain bubbles between layers so diff outputs can settle.
module backprop_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int ROW_W      = 8,
  parameter int PIPE_DEPTH = 4,
  parameter int LR_W       = 16,
  parameter int BPC_W      = 66
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        stall_i,
  input  logic [LR_W-1:0]             learning_rate_in_i,
  input  logic [NUM_LAYERS*ROW_W-1:0] layer_rows_i,
  output logic [BPC_W-1:0]            backprop_controll_o,
  output logic [LR_W-1:0]             learning_rate_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [LW-1:0] TOP_LAYER = LW'(NUM_LAYERS - 1);

  typedef struct packed {
    logic        valid;
    logic        cost;
    logic [31:0] layer;
    logic [31:0] row;
  } bpc_t;

  typedef enum logic [2:0] {S_IDLE, S_COST, S_ISSUE, S_DRAIN, S_DONE} state_t;

  // Padded to a power of two so any layer index value selects a defined entry.
  logic [ROW_W-1:0] rows_a [2**LW];

  for (genvar k = 0; k < 2**LW; k++) begin : g_rows
    if (k < NUM_LAYERS) begin : g_used
      assign rows_a[k] = layer_rows_i[k*ROW_W +: ROW_W];
    end else begin : g_pad
      assign rows_a[k] = '0;
    end
  end

  state_t           state_q, state_d;
  logic [LW-1:0]    layer_q, layer_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [LR_W-1:0]  lr_q, lr_d;
  logic             cost_pend_q, cost_pend_d;
  logic             last_q, last_d;
  bpc_t             bpc_q, bpc_d;

  logic             advance, go_slot;
  logic [LW-1:0]    slot_layer;
  logic [ROW_W-1:0] slot_row, slot_rows;

  // The word and state registered at an edge describe the cycle being entered,
  // so stall sampled at that edge decides whether the entered slot issues.
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    row_d       = row_q;
    drain_d     = drain_q;
    lr_d        = lr_q;
    cost_pend_d = cost_pend_q;
    last_d      = 1'b0;
    bpc_d       = '0;
    advance     = 1'b0;
    go_slot     = 1'b0;
    slot_layer  = layer_q;
    slot_row    = row_q;
    slot_rows   = '0;

    case (state_q)
      S_IDLE: if (start_i) begin
        lr_d        = learning_rate_in_i;
        layer_d     = TOP_LAYER;
        row_d       = '0;
        state_d     = S_COST;
        cost_pend_d = 1'b1;
        if (!stall_i) begin
          bpc_d       = '{1'b1, 1'b1, 32'(NUM_LAYERS - 1), 32'd0};
          cost_pend_d = 1'b0;
        end
      end
      S_COST: begin
        if (cost_pend_q) begin
          if (!stall_i) begin
            bpc_d       = '{1'b1, 1'b1, 32'(NUM_LAYERS - 1), 32'd0};
            cost_pend_d = 1'b0;
          end
        end else begin
          go_slot = 1'b1;
        end
      end
      S_ISSUE: begin
        if (rows_a[layer_q] == '0) begin
          advance = 1'b1;
        end else if (last_q) begin
          state_d = S_DRAIN;
          drain_d = DW'(PIPE_DEPTH - 1);
        end else begin
          go_slot = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q != '0) drain_d = drain_q - 1'b1;
        else               advance = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (layer_q == '0) begin
        state_d = S_DONE;
      end else begin
        slot_layer = layer_q - 1'b1;
        slot_row   = '0;
        layer_d    = slot_layer;
        row_d      = '0;
        go_slot    = 1'b1;
      end
    end

    slot_rows = rows_a[slot_layer];

    // An empty layer still occupies one ISSUE cycle but emits nothing.
    if (go_slot) begin
      state_d = S_ISSUE;
      if (slot_rows != '0 && !stall_i) begin
        bpc_d  = '{1'b1, 1'b0, 32'(slot_layer), 32'(slot_row)};
        row_d  = slot_row + 1'b1;
        last_d = (slot_row == slot_rows - 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      layer_q     <= '0;
      row_q       <= '0;
      drain_q     <= '0;
      lr_q        <= '0;
      cost_pend_q <= 1'b0;
      last_q      <= 1'b0;
      bpc_q       <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      lr_q        <= lr_d;
      cost_pend_q <= cost_pend_d;
      last_q      <= last_d;
      bpc_q       <= bpc_d;
    end
  end

  assign backprop_controll_o = bpc_q;
  assign learning_rate_o     = lr_q;
  assign busy_o              = (state_q != S_IDLE);
  assign done_o              = (state_q == S_DONE);

endmodule

// File: tb/tb_backprop_sequencer.sv
// Bench for backprop_sequencer: a queue-of-slots model of each pass checked every
// cycle, plus literal cycle/word expectations for the directed scenarios.
module tb_backprop_sequencer;
  localparam int NL = 3, RW = 8, PD = 4, LRW = 16;
  localparam logic [65:0] COST_W = 66'h3_00000002_00000000;
  localparam int M_NOM = 0, M_STALL = 1, M_BUSY = 2, M_ABORT = 3, M_RAND = 4;
  localparam int BOUND = 600;

  logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
  logic [LRW-1:0] lr_in = '0;
  logic [NL*RW-1:0] layer_rows = '0;
  logic [65:0]    bpc;
  logic [LRW-1:0] lr_out;
  logic           busy, done;

  backprop_sequencer #(.NUM_LAYERS(NL), .ROW_W(RW), .PIPE_DEPTH(PD), .LR_W(LRW), .BPC_W(66)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stall_i(stall),
    .learning_rate_in_i(lr_in), .layer_rows_i(layer_rows),
    .backprop_controll_o(bpc), .learning_rate_o(lr_out), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a pass is a list of slots; words wait out stalls, bubbles/skips/done never do.
  typedef struct packed {
    logic [65:0] w;
    logic        is_word;
    logic        is_done;
  } slot_t;

  slot_t          mq[$];
  logic [65:0]    m_w = '0;
  logic           m_busy = 1'b0, m_done = 1'b0;
  logic [LRW-1:0] m_lr = '0;

  task automatic push_slot(input logic [65:0] w, input logic is_word, input logic is_done);
    slot_t s;
    s.w = w; s.is_word = is_word; s.is_done = is_done;
    mq.push_back(s);
  endtask

  task automatic build_pass(input logic [NL*RW-1:0] r);
    int n;
    push_slot({1'b1, 1'b1, 32'(NL - 1), 32'd0}, 1'b1, 1'b0);
    for (int l = NL - 1; l >= 0; l--) begin
      n = int'(r[l*RW +: RW]);
      if (n == 0) push_slot('0, 1'b0, 1'b0);
      else begin
        for (int i = 0; i < n; i++) push_slot({1'b1, 1'b0, 32'(l), 32'(i)}, 1'b1, 1'b0);
        for (int b = 0; b < PD; b++) push_slot('0, 1'b0, 1'b0);
      end
    end
    push_slot('0, 1'b0, 1'b1);
  endtask

  initial begin : model_cmp
    logic s_rst, s_start, s_stall;
    logic [LRW-1:0] s_lr;
    logic [NL*RW-1:0] s_rows;
    slot_t sl;
    forever begin
      @(posedge clk);
      s_rst = rst_n; s_start = start; s_stall = stall; s_lr = lr_in; s_rows = layer_rows;
      @(negedge clk);
      if (!rst_n) begin
        mq.delete(); m_w = '0; m_busy = 1'b0; m_done = 1'b0; m_lr = '0;
      end else if (s_rst) begin
        m_w = '0; m_done = 1'b0;
        if (mq.size() == 0 && !m_busy && s_start) begin
          m_lr = s_lr;
          build_pass(s_rows);
        end
        if (mq.size() == 0) m_busy = 1'b0;
        else begin
          m_busy = 1'b1;
          if (!(mq[0].is_word && s_stall)) begin
            sl = mq.pop_front();
            m_w = sl.is_word ? sl.w : '0;
            m_done = sl.is_done;
          end
        end
      end
      chk("word", bpc, m_w);
      chk("busy", 66'(busy), 66'(m_busy));
      chk("done", 66'(done), 66'(m_done));
      chk("lr", 66'(lr_out), 66'(m_lr));
    end
  end

  // Called at a negedge; start is sampled at the next edge, so cycle 1 is the one after it.
  task automatic run_pass(input logic [NL*RW-1:0] rows, input logic [LRW-1:0] lr, input int mode,
                          output int done_k, output logic [65:0] first_w);
    done_k = -1;
    first_w = '0;
    layer_rows = rows; lr_in = lr; start = 1'b1;
    stall = (mode == M_RAND) ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int k = 1; k <= BOUND; k++) begin
      @(negedge clk);
      start = 1'b0; stall = 1'b0;
      if (k == 1) first_w = bpc;
      case (mode)
        M_STALL: if (k == 2 || k == 3 || (k >= 6 && k <= 9)) stall = 1'b1;
        M_BUSY:  if (k == 4) begin start = 1'b1; lr_in = 16'h0100; end
        M_ABORT: if (k == 10) begin done_k = -2; return; end
        M_RAND: begin
          stall = ($urandom_range(0, 3) == 0);
          start = ($urandom_range(0, 7) == 0);
          lr_in = 16'($urandom);
        end
        default: ;
      endcase
      if (done) begin done_k = k; return; end
    end
  endtask

  initial begin : stim
    int dk;
    logic [65:0] fw;
    logic [NL*RW-1:0] rr;

    repeat (2) @(negedge clk);
    chk("reset_word", bpc, '0);
    chk("reset_busy", 66'(busy), '0);
    chk("reset_done", 66'(done), '0);
    chk("reset_lr", 66'(lr_out), '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_pass(24'h030303, 16'h0080, M_NOM, dk, fw);
    chk("nom_cost_word", fw, COST_W);
    chk("nom_done_cycle", 66'(dk), 66'd23);
    chk("nom_lr", 66'(lr_out), 66'h0080);

    // start held through the DONE cycle edge must be ignored
    start = 1'b1; lr_in = 16'h0055;
    @(negedge clk);
    chk("b2b_idle_busy", 66'(busy), '0);
    run_pass(24'h030303, 16'h0055, M_NOM, dk, fw);
    chk("b2b_cost_word", fw, COST_W);
    chk("b2b_done_cycle", 66'(dk), 66'd23);
    chk("b2b_lr", 66'(lr_out), 66'h0055);

    @(negedge clk);
    run_pass(24'h030303, 16'h0080, M_STALL, dk, fw);
    chk("stall_done_cycle", 66'(dk), 66'd25);

    @(negedge clk);
    run_pass(24'h030003, 16'h0080, M_NOM, dk, fw);
    chk("empty_done_cycle", 66'(dk), 66'd17);

    @(negedge clk);
    run_pass(24'h030303, 16'h0080, M_BUSY, dk, fw);
    chk("busy_start_done_cycle", 66'(dk), 66'd23);
    chk("busy_start_lr", 66'(lr_out), 66'h0080);

    @(negedge clk);
    run_pass(24'h030303, 16'h0080, M_ABORT, dk, fw);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_word", bpc, '0);
    chk("abort_busy", 66'(busy), '0);
    chk("abort_done", 66'(done), '0);
    chk("abort_lr", 66'(lr_out), '0);
    @(negedge clk);
    chk("abort_no_done", 66'(done), '0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_pass(24'h030303, 16'h0080, M_NOM, dk, fw);
    chk("post_abort_cost", fw, COST_W);
    chk("post_abort_done_cycle", 66'(dk), 66'd23);

    @(negedge clk);
    run_pass(24'hFF0001, 16'h1234, M_NOM, dk, fw);
    chk("max_rows_done_cycle", 66'(dk), 66'd267);

    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) rr[l*RW +: RW] = 8'($urandom_range(0, 5));
      run_pass(rr, 16'($urandom), M_RAND, dk, fw);
      chk("rand_pass_finished", 66'(dk < 0), '0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
